udp_hdmi_send: RTL

Transmit-side counterpart of the UDP frame receiver. On a start pulse, the block reads one burst of 1–256 32-bit words from DRAM through the DRAM read command/data FIFOs into a local buffer. It then sends that burst as one contiguous UDP packet on the UDP stack's `w_req`/`w_ack`/`w_enable`/`w_data` write interface. The packet has a 4-word header, a word-offset word, and the payload. The block sits between the DRAM controller's read port and the UDP/IP core and serves frame readback and streaming.

---
 rtl/udp_hdmi_pkg.sv | 47 ++++
 rtl/udp_send_buf.sv | 26 ++
 rtl/udp_hdmi_send.sv | 132 +++++++++++++
 3 files changed

// File: rtl/udp_hdmi_pkg.sv
// Shared definitions for the UDP transmit path: header layout, field widths,
// DRAM read-command packing and the sender state encoding.
package udp_hdmi_pkg;

    localparam int          HDR_WORDS    = 4;
    localparam logic [31:0] HDR_RESERVED = 32'h0;
    localparam int          LEN_W        = 8;
    localparam int          ADDR_W       = 32;
    localparam int          DATA_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FILL,
        S_WAIT_ACK,
        S_HDR,
        S_OFS,
        S_DATA,
        S_DONE
    } state_t;

    // The DRAM controller takes byte addresses; the top two word-address bits fall off.
    function automatic logic [LEN_W+ADDR_W-1:0] pack_rd_ctrl(
        input logic [LEN_W-1:0]  len_m1,
        input logic [ADDR_W-1:0] word_addr
    );
        return {len_m1, word_addr << 2};
    endfunction

    function automatic logic [DATA_W-1:0] hdr_word(
        input logic [1:0]        idx,
        input logic [ADDR_W-1:0] ip,
        input logic [15:0]       sport,
        input logic [15:0]       dport,
        input logic [LEN_W-1:0]  len_m1
    );
        logic [DATA_W-1:0] n_words;
        n_words = DATA_W'(len_m1) + DATA_W'(1);
        case (idx)
            2'd0:    return ip;
            2'd1:    return {sport, dport};
            2'd2:    return HDR_RESERVED;
            default: return n_words << 2;
        endcase
    endfunction

endpackage

// File: rtl/udp_send_buf.sv
// Burst staging buffer: simple dual-port RAM, one write port, one read port
// with a registered (1-cycle) read.
module udp_send_buf
    import udp_hdmi_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // NOTE: no reset on the array or read register, so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_hdmi_send.sv
// Reads one DRAM burst into a local buffer, then sends it as a single
// contiguous UDP packet: 4 header words, the word offset, then the payload.
module udp_hdmi_send
    import udp_hdmi_pkg::*;
#(
    parameter int BUF_DEPTH_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             start_addr,
    input  logic [7:0]              start_len_m1,
    input  logic [31:0]             dst_ip,
    input  logic [15:0]             dst_port,
    input  logic [15:0]             src_port,
    output logic                    busy,
    output logic                    done,
    output logic [39:0]             rd_ctrl_in,
    output logic                    rd_ctrl_we,
    input  logic [31:0]             rd_data,
    input  logic                    rd_empty,
    output logic                    rd_re,
    output logic                    w_req,
    input  logic                    w_ack,
    output logic                    w_enable,
    output logic [31:0]             w_data
);

    localparam int AW    = BUF_DEPTH_LOG2;
    localparam int CNT_W = BUF_DEPTH_LOG2 + 1;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ip_q;
    logic [15:0]       dport_q;
    logic [15:0]       sport_q;
    logic [LEN_W-1:0]  len_m1_q;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  data_cnt;
    logic [CNT_W-1:0]  last_idx;
    logic [1:0]        hdr_cnt;

    logic              w_req_nxt;
    logic              w_en_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [DATA_W-1:0] w_data_q;
    logic [DATA_W-1:0] buf_q;
    logic [AW-1:0]     buf_raddr;

    assign last_idx   = CNT_W'(len_m1_q);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign rd_re      = (state == S_FILL) && !rd_empty;
    assign rd_ctrl_we = (state == S_CMD);
    assign rd_ctrl_in = (state == S_CMD) ? pack_rd_ctrl(len_m1_q, addr_q) : '0;

    // Read address leads the emitted word by one; OFS primes address 0.
    assign buf_raddr  = (state == S_DATA) ? data_cnt[AW-1:0] + AW'(1) : '0;
    assign w_data     = (state == S_DATA) ? buf_q : w_data_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        w_data_nxt = '0;
        case (state)
            S_IDLE:     if (start) state_nxt = S_CMD;
            S_CMD:      state_nxt = S_FILL;
            S_FILL:     if (!rd_empty && fill_cnt == last_idx) state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (w_ack) begin
                            state_nxt  = S_HDR;
                            w_data_nxt = ip_q;
                        end
            S_HDR:      if (hdr_cnt == 2'(HDR_WORDS - 1)) begin
                            state_nxt  = S_OFS;
                            w_data_nxt = addr_q;
                        end else begin
                            w_data_nxt = hdr_word(hdr_cnt + 2'd1, ip_q, sport_q, dport_q, len_m1_q);
                        end
            S_OFS:      state_nxt = S_DATA;
            S_DATA:     if (data_cnt == last_idx) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        w_req_nxt = state_nxt inside {S_WAIT_ACK, S_HDR, S_OFS, S_DATA};
        w_en_nxt  = state_nxt inside {S_HDR, S_OFS, S_DATA};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            w_req    <= 1'b0;
            w_enable <= 1'b0;
            w_data_q <= '0;
        end else begin
            state    <= state_nxt;
            w_req    <= w_req_nxt;
            w_enable <= w_en_nxt;
            w_data_q <= w_data_nxt;
        end
    end

    // Datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            addr_q   <= start_addr;
            len_m1_q <= start_len_m1;
            ip_q     <= dst_ip;
            dport_q  <= dst_port;
            sport_q  <= src_port;
        end
        if (state == S_CMD)       fill_cnt <= '0;
        else if (rd_re)           fill_cnt <= fill_cnt + CNT_W'(1);
        if (state == S_WAIT_ACK)  hdr_cnt  <= '0;
        else if (state == S_HDR)  hdr_cnt  <= hdr_cnt + 2'd1;
        if (state == S_OFS)       data_cnt <= '0;
        else if (state == S_DATA) data_cnt <= data_cnt + CNT_W'(1);
    end

    udp_send_buf #(
        .ADDR_BITS (AW)
    ) u_buf (
        .clk   (clk),
        .we    (rd_re),
        .waddr (fill_cnt[AW-1:0]),
        .wdata (rd_data),
        .raddr (buf_raddr),
        .rdata (buf_q)
    );

endmodule
